i2s_playback_dma_fifo: RTL
==========================

# i2s_playback_dma_fifo

Parametrised multi-channel playback buffer between the HPS DMA peripheral-request interface and the I2S serialiser, successor to the fixed 64-bit stereo playback FIFO. Accepts frames of CHANNELS×SAMPLE_W bits from the FPGA-to-HPS DMA write path and raises burst or single DMA requests from free space. Hands frames to the serialiser on a per-frame strobe and tracks underflow. One clock domain; the serialiser side is already synchronised to `clk`.

## Interface
- CHANNELS, 2, audio channels per frame (1..8)
- SAMPLE_W, 24, bits per sample (16..32)
- DEPTH, 64, FIFO depth in frames, power of two, ≥ 2×BURST
- BURST, 8, frames per DMA burst request, < DEPTH
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dma_enable  in  1  request generation enable; low flushes FIFO
- dma_req  out  1  burst request
- dma_single  out  1  single-frame request
- dma_ack  in  1  one-cycle acknowledge from HPS DMA
- wr_data  in  CHANNELS*SAMPLE_W  frame, channel 0 in LSBs
- wr_valid  in  1  frame write strobe
- wr_ready  out  1  FIFO not full
- rd_req  in  1  one-cycle frame strobe from serialiser
- rd_data  out  CHANNELS*SAMPLE_W  frame to serialiser
- rd_valid  out  1  rd_data updated this cycle
- level  out  $clog2(DEPTH)+1  frames held
- underflow  out  1  sticky, set on rd_req while empty
- underflow_cnt  out  16  underflow event count

## Operation
- Reset: level=0, dma_req=0, dma_single=0, wr_ready=1, rd_data=0, rd_valid=0, underflow=0, underflow_cnt=0, FSM=IDLE.
- Write accepted when wr_valid && wr_ready; wr_valid while full is dropped, level unchanged.
- rd_req with level>0: pop head, rd_data registered. rd_req with level=0: rd_data forced to 0, underflow set, underflow_cnt +1 saturating at 16'hFFFF.
- Simultaneous write and read: level unchanged; on empty FIFO the read underflows (no write-through bypass), write is stored.
- underflow clears only on reset or a dma_enable falling edge.
- free = DEPTH − level. FSM states:
  - IDLE: dma_enable low → stay. free ≥ BURST → REQ_BURST. 1 ≤ free < BURST → REQ_SINGLE.
  - REQ_BURST: dma_req=1 until dma_ack → XFER, remaining=BURST.
  - REQ_SINGLE: dma_single=1 until dma_ack → XFER, remaining=1.
  - XFER: each accepted write decrements remaining; remaining=0 → IDLE. dma_req/dma_single low.
  - dma_enable low in any state → IDLE next cycle, requests deasserted, FIFO flushed (level=0); underflow held until next cycle's clear.
- dma_ack outside REQ_* is ignored.

## Timing
- Write to level update: 1 cycle.
- rd_req to rd_data/rd_valid: 1 cycle; rd_valid is a 1-cycle pulse, also on underflow reads.
- IDLE to request asserted: 1 cycle after free condition holds.
- dma_ack to request deasserted: same edge (request low on next cycle).
- Minimum request-to-request spacing: 1 IDLE cycle after XFER completes.
- wr_ready reflects registered level (combinational from level==DEPTH).
- Reset mid-burst: all state to reset values next edge; outstanding DMA writes then land in an empty FIFO.

## Configuration
- I2S_PB_UNDERFLOW_HOLD_EN defined: underflow read repeats last valid frame on rd_data instead of zeros; underflow flag and count still update.
- Undefined: underflow read drives zeros (mute).

## Structure
- Package i2s_pb_pkg: FSM state enum (IDLE, REQ_BURST, REQ_SINGLE, XFER), level-width function, UNDERFLOW_CNT_MAX constant.
- Sub-module i2s_pb_fifo_ram: simple dual-port, registered read, DEPTH×(CHANNELS*SAMPLE_W), inferred RAM.
- Top holds pointers, level, FSM, underflow logic.

## Test plan
- Reset, dma_enable=1, DEPTH=64, BURST=8 → dma_req=1 within 2 cycles; ack, write 8 frames → level=8, FSM returns IDLE, dma_req reasserts.
- Fill to level=60 → dma_single=1 (free=4<8), dma_req=0; ack + 1 write → level=61.
- Fill to 64, drive wr_valid with 0xABCDEF → wr_ready=0, level stays 64, no dma request; rd_req → rd_data equals oldest frame, level=63.
- Empty FIFO, rd_req ×3 → rd_data=0 (or last frame with I2S_PB_UNDERFLOW_HOLD_EN), underflow=1, underflow_cnt=3.
- Write and rd_req same cycle at level=0 → underflow event, level=1 next cycle; at level=5 → level stays 5.
- Deassert dma_enable during REQ_BURST with level=20 → dma_req=0, level=0 next cycle, underflow cleared.

Source files
------------

// File: rtl/i2s_pb_pkg.sv
// Shared types and constants for the multi-channel I2S playback DMA FIFO.
package i2s_pb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ_BURST,
        REQ_SINGLE,
        XFER
    } pb_state_t;

    localparam logic [15:0] UNDERFLOW_CNT_MAX = 16'hFFFF;

    // Level must represent 0..DEPTH inclusive, hence one bit above the address width.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/i2s_pb_fifo_ram.sv
// Simple dual-port frame store with registered read, intended for RAM inference.
module i2s_pb_fifo_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 48
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/i2s_playback_dma_fifo.sv
// Playback buffer between HPS DMA requests and the I2S serialiser.
// Optional build macro: I2S_PB_UNDERFLOW_HOLD_EN (underflow reads repeat the last frame).
module i2s_playback_dma_fifo
    import i2s_pb_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned SAMPLE_W = 24,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned BURST    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         dma_enable,
    output logic                         dma_req,
    output logic                         dma_single,
    input  logic                         dma_ack,
    input  logic [CHANNELS*SAMPLE_W-1:0] wr_data,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic                         rd_req,
    output logic [CHANNELS*SAMPLE_W-1:0] rd_data,
    output logic                         rd_valid,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         underflow,
    output logic [15:0]                  underflow_cnt
);

    localparam int unsigned FW = CHANNELS * SAMPLE_W;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = level_w(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] BURST_L = LW'(BURST);
    localparam logic [LW-1:0] ONE_L   = LW'(1);

`ifdef I2S_PB_UNDERFLOW_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    pb_state_t     state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] remaining;
    logic [LW-1:0] free;
    logic          en_q;
    logic          show_q;
    logic          wr_en;
    logic          pop;
    logic          under;
    logic          en_fall;
    logic [FW-1:0] ram_q;

    assign wr_ready = (level != DEPTH_L);
    assign wr_en    = wr_valid && wr_ready && dma_enable;
    assign pop      = rd_req && (level != '0);
    assign under    = rd_req && (level == '0);
    assign en_fall  = en_q && !dma_enable;
    assign free     = DEPTH_L - level;

    // The RAM output only advances on a pop, so it already holds the last frame;
    // show_q selects between that frame and mute.
    assign rd_data = show_q ? ram_q : '0;

    i2s_pb_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_addr (rd_ptr),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            level         <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            rd_valid      <= 1'b0;
            show_q        <= 1'b0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
            en_q          <= 1'b0;
        end else begin
            en_q     <= dma_enable;
            rd_valid <= rd_req;
            if (!dma_enable) begin
                level  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                level <= level + LW'(wr_en) - LW'(pop);
            end
            if (pop) begin
                show_q <= 1'b1;
            end else if (under && !HOLD_EN) begin
                show_q <= 1'b0;
            end
            if (en_fall) begin
                underflow <= 1'b0;
            end else if (under) begin
                underflow <= 1'b1;
            end
            if (under && (underflow_cnt != UNDERFLOW_CNT_MAX)) begin
                underflow_cnt <= underflow_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !dma_enable) begin
            state      <= IDLE;
            dma_req    <= 1'b0;
            dma_single <= 1'b0;
            remaining  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (free >= BURST_L) begin
                        state   <= REQ_BURST;
                        dma_req <= 1'b1;
                    end else if (free != '0) begin
                        state      <= REQ_SINGLE;
                        dma_single <= 1'b1;
                    end
                end
                REQ_BURST: begin
                    if (dma_ack) begin
                        state     <= XFER;
                        dma_req   <= 1'b0;
                        remaining <= BURST_L;
                    end
                end
                REQ_SINGLE: begin
                    if (dma_ack) begin
                        state      <= XFER;
                        dma_single <= 1'b0;
                        remaining  <= ONE_L;
                    end
                end
                XFER: begin
                    if (wr_en) begin
                        remaining <= remaining - ONE_L;
                        if (remaining == ONE_L) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
